// File: rtl/memu_resp.sv
// memu_resp: memory-access pipeline stage between EXE and WB.
// Holds one EXE bundle, waits for the data-SRAM response of the access EXE
// issued, aligns and sign/zero-extends load data, and forwards the
// write-back value to WB plus hazard/bypass information to ID.
module memu_resp #(
   parameter int unsigned IN_LEN  = 75,
   parameter int unsigned OUT_LEN = 70
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               exe_to_mem_valid,
   output logic               mem_allowin,
   input  logic [IN_LEN-1:0]  exe_to_mem_zip,
   input  logic               wb_allowin,
   output logic               mem_to_wb_valid,
   output logic [OUT_LEN-1:0] mem_to_wb_zip,
   input  logic               data_sram_data_ok,
   input  logic [31:0]        data_sram_rdata,
   output logic [38:0]        mem_rf_zip
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HELD = 2'd2
   } state_t;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_B  = 3'b001;
   localparam logic [2:0] LD_H  = 3'b010;
   localparam logic [2:0] LD_BU = 3'b011;
   localparam logic [2:0] LD_HU = 3'b100;

   state_t              state;
   state_t              state_nxt;
   logic                mem_valid;
   logic [IN_LEN-1:0]   mem_zip;
   logic [31:0]         rdata_buf;

   logic                ready_go;
   logic                accept;
   logic                leave;
   logic                capture;

   // Fields of the latched entry.
   logic [2:0]          ld_op;
   logic                mem_we;
   logic                res_from_mem;
   logic                rf_we;
   logic [4:0]          rf_waddr;
   logic [31:0]         alu_result;
   logic [31:0]         pc;

   // need_resp of the incoming EXE bundle decides the state of a new entry.
   logic                in_need_resp;

   logic [31:0]         raw;
   logic [1:0]          addr_lo;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;
   logic [31:0]         ld_result;
   logic [31:0]         final_result;
   logic                mem_busy;

   assign {ld_op, mem_we, res_from_mem, rf_we, rf_waddr, alu_result, pc} = mem_zip;
   assign in_need_resp = exe_to_mem_zip[71] | exe_to_mem_zip[70];

   // A WAIT entry completes on data_ok; every other valid entry is complete.
   assign ready_go    = (state == WAIT) ? data_sram_data_ok : 1'b1;
   assign leave       = mem_valid & ready_go & wb_allowin;
   assign mem_allowin = ~mem_valid | (ready_go & wb_allowin);
   assign accept      = exe_to_mem_valid & mem_allowin;
   assign capture     = (state == WAIT) & data_sram_data_ok & ~wb_allowin;

   assign mem_to_wb_valid = mem_valid & ready_go;

   // Entry register: latch a new bundle or drop the one leaving to WB.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_valid <= 1'b0;
         mem_zip   <= '0;
      end else begin
         if (accept) begin
            mem_valid <= 1'b1;
            mem_zip   <= exe_to_mem_zip;
         end else begin
            mem_valid <= mem_valid & ~leave;
         end
      end
   end

   // Response-tracking state register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: a freshly accepted entry always restarts from its own
   // need_resp; data_ok seen in IDLE or HELD is stale and ignored.
   always_comb begin
      state_nxt = state;
      if (accept) begin
         state_nxt = in_need_resp ? WAIT : IDLE;
      end else begin
         unique case (state)
            IDLE: state_nxt = IDLE;
            WAIT: begin
               if (data_sram_data_ok) begin
                  state_nxt = wb_allowin ? IDLE : HELD;
               end
            end
            HELD: begin
               if (wb_allowin) begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Buffer the read data when the response arrives while WB is stalled.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rdata_buf <= '0;
      end else if (capture) begin
         rdata_buf <= data_sram_rdata;
      end
   end

   assign raw     = (state == HELD) ? rdata_buf : data_sram_rdata;
   assign addr_lo = alu_result[1:0];

   // Byte/halfword selection; a[0] is ignored for halfwords.
   always_comb begin
      ld_byte = raw[7:0];
      unique case (addr_lo)
         2'd0: ld_byte = raw[7:0];
         2'd1: ld_byte = raw[15:8];
         2'd2: ld_byte = raw[23:16];
         2'd3: ld_byte = raw[31:24];
         default: ld_byte = raw[7:0];
      endcase
      ld_half = addr_lo[1] ? raw[31:16] : raw[15:0];
   end

   // Load extension; unlisted ld_op encodings behave as a word load.
   always_comb begin
      ld_result = raw;
      case (ld_op)
         LD_W:  ld_result = raw;
         LD_B:  ld_result = {{24{ld_byte[7]}}, ld_byte};
         LD_BU: ld_result = {24'd0, ld_byte};
         LD_H:  ld_result = {{16{ld_half[15]}}, ld_half};
         LD_HU: ld_result = {16'd0, ld_half};
         default: ld_result = raw;
      endcase
   end

   assign final_result = res_from_mem ? ld_result : alu_result;
   assign mem_busy     = mem_valid & res_from_mem & ~ready_go;

   assign mem_to_wb_zip = {rf_we & mem_valid, rf_waddr, final_result, pc};
   assign mem_rf_zip    = {mem_busy, rf_we & mem_valid, rf_waddr, final_result};

endmodule

// File: tb/tb_memu_resp.sv
// tb_memu_resp: directed-vector bench for the memu_resp stage.
module tb_memu_resp;

   logic        clk;
   logic        resetn;
   logic        exe_to_mem_valid;
   logic        mem_allowin;
   logic [74:0] exe_to_mem_zip;
   logic        wb_allowin;
   logic        mem_to_wb_valid;
   logic [69:0] mem_to_wb_zip;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [38:0] mem_rf_zip;

   int unsigned n_vec;
   int unsigned n_bad;

   memu_resp #(
      .IN_LEN (75),
      .OUT_LEN(70)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .exe_to_mem_valid (exe_to_mem_valid),
      .mem_allowin      (mem_allowin),
      .exe_to_mem_zip   (exe_to_mem_zip),
      .wb_allowin       (wb_allowin),
      .mem_to_wb_valid  (mem_to_wb_valid),
      .mem_to_wb_zip    (mem_to_wb_zip),
      .data_sram_data_ok(data_sram_data_ok),
      .data_sram_rdata  (data_sram_rdata),
      .mem_rf_zip       (mem_rf_zip)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [74:0] mk(input logic [2:0] ld_op, input logic we,
                                      input logic rfm, input logic rfwe,
                                      input logic [4:0] waddr, input logic [31:0] alu,
                                      input logic [31:0] pc);
      return {ld_op, we, rfm, rfwe, waddr, alu, pc};
   endfunction

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after driving inputs.
   task automatic settle();
      #1;
   endtask

   // Accept a load, return data_ok on the following cycle, check the result.
   task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rd, input logic [31:0] exp);
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(op, 1'b0, 1'b1, 1'b1, 5'd3, addr, 32'h1c00_0100);
      step();
      exe_to_mem_valid  = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rd;
      settle();
      chk({tag, "_valid"}, {31'd0, mem_to_wb_valid}, 32'd1);
      chk({tag, "_final"}, mem_to_wb_zip[63:32], exp);
      step();
      data_sram_data_ok = 1'b0;
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      resetn            = 1'b0;
      exe_to_mem_valid  = 1'b0;
      exe_to_mem_zip    = '0;
      wb_allowin        = 1'b1;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = '0;
      step();
      step();
      settle();
      chk("rst_allowin", {31'd0, mem_allowin}, 32'd1);
      chk("rst_wbvalid", {31'd0, mem_to_wb_valid}, 32'd0);
      chk("rst_busy_rfwe", {30'd0, mem_rf_zip[38:37]}, 32'd0);
      resetn = 1'b1;

      // Non-memory ALU op.
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(3'b000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0000);
      step();
      exe_to_mem_valid = 1'b0;
      settle();
      chk("alu_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("alu_final", mem_to_wb_zip[63:32], 32'h0000_1234);
      chk("alu_rfwe_waddr", {26'd0, mem_to_wb_zip[69:64]}, 32'h25);
      chk("alu_allowin", {31'd0, mem_allowin}, 32'd1);
      chk("alu_bypass", mem_rf_zip[31:0], 32'h0000_1234);
      step();
      settle();
      chk("alu_gone", {31'd0, mem_to_wb_valid}, 32'd0);

      // ld.w with data_ok three cycles after the busy window starts.
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(3'b000, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_0100, 32'h1c00_0004);
      step();
      exe_to_mem_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("ldw_busy", {31'd0, mem_rf_zip[38]}, 32'd1);
         chk("ldw_allowin", {31'd0, mem_allowin}, 32'd0);
         chk("ldw_wbvalid", {31'd0, mem_to_wb_valid}, 32'd0);
         step();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_BEEF;
      settle();
      chk("ldw_ok_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("ldw_ok_final", mem_to_wb_zip[63:32], 32'hDEAD_BEEF);
      chk("ldw_ok_busy", {31'd0, mem_rf_zip[38]}, 32'd0);
      chk("ldw_ok_allowin", {31'd0, mem_allowin}, 32'd1);
      step();
      data_sram_data_ok = 1'b0;

      // Sub-word loads.
      do_load("ldb",  3'b001, 32'h0000_0103, 32'h80FF_0011, 32'hFFFF_FF80);
      do_load("ldbu", 3'b011, 32'h0000_0103, 32'h80FF_0011, 32'h0000_0080);
      do_load("ldh",  3'b010, 32'h0000_0102, 32'h80FF_0011, 32'hFFFF_80FF);
      do_load("ldhu", 3'b100, 32'h0000_0100, 32'h80FF_0011, 32'h0000_0011);
      do_load("ldb1", 3'b001, 32'h0000_0101, 32'h80FF_0011, 32'h0000_0000);

      // ld.w held while WB stalls.
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(3'b000, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_0200, 32'h1c00_0008);
      step();
      exe_to_mem_valid  = 1'b0;
      wb_allowin        = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hCAFE_F00D;
      settle();
      chk("held_ok_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("held_ok_allowin", {31'd0, mem_allowin}, 32'd0);
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h1234_5678;
      settle();
      chk("held1_final", mem_to_wb_zip[63:32], 32'hCAFE_F00D);
      chk("held1_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("held1_busy", {31'd0, mem_rf_zip[38]}, 32'd0);
      step();
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0000_0000;
      settle();
      chk("held2_final", mem_to_wb_zip[63:32], 32'hCAFE_F00D);
      chk("held2_allowin", {31'd0, mem_allowin}, 32'd0);
      step();
      data_sram_data_ok = 1'b0;
      wb_allowin        = 1'b1;
      settle();
      chk("held_rel_final", mem_to_wb_zip[63:32], 32'hCAFE_F00D);
      chk("held_rel_allowin", {31'd0, mem_allowin}, 32'd1);
      step();
      settle();
      chk("held_gone", {31'd0, mem_to_wb_valid}, 32'd0);

      // Store followed back-to-back by an ALU op.
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0300, 32'h1c00_000c);
      step();
      exe_to_mem_zip   = mk(3'b000, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0000_0055, 32'h1c00_0010);
      settle();
      chk("st_wait_allowin", {31'd0, mem_allowin}, 32'd0);
      chk("st_wait_valid", {31'd0, mem_to_wb_valid}, 32'd0);
      chk("st_wait_busy", {31'd0, mem_rf_zip[38]}, 32'd0);
      step();
      data_sram_data_ok = 1'b1;
      settle();
      chk("st_ok_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("st_ok_allowin", {31'd0, mem_allowin}, 32'd1);
      chk("st_ok_rfwe", {31'd0, mem_to_wb_zip[69]}, 32'd0);
      chk("st_ok_final", mem_to_wb_zip[63:32], 32'h0000_0300);
      step();
      exe_to_mem_valid  = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hFFFF_FFFF;
      wb_allowin        = 1'b0;
      settle();
      chk("b2b_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("b2b_final", mem_to_wb_zip[63:32], 32'h0000_0055);
      step();
      data_sram_data_ok = 1'b0;
      settle();
      chk("stale_valid", {31'd0, mem_to_wb_valid}, 32'd1);
      chk("stale_final", mem_to_wb_zip[63:32], 32'h0000_0055);
      chk("stale_allowin", {31'd0, mem_allowin}, 32'd0);
      wb_allowin = 1'b1;
      step();
      settle();
      chk("b2b_gone", {31'd0, mem_to_wb_valid}, 32'd0);

      // Reset while waiting for a load response.
      exe_to_mem_valid = 1'b1;
      exe_to_mem_zip   = mk(3'b000, 1'b0, 1'b1, 1'b1, 5'd2, 32'h0000_0400, 32'h1c00_0014);
      step();
      exe_to_mem_valid = 1'b0;
      settle();
      chk("rw_busy", {31'd0, mem_rf_zip[38]}, 32'd1);
      resetn = 1'b0;
      step();
      resetn            = 1'b1;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h5555_AAAA;
      settle();
      chk("rw_allowin", {31'd0, mem_allowin}, 32'd1);
      chk("rw_valid", {31'd0, mem_to_wb_valid}, 32'd0);
      chk("rw_busy_rfwe", {30'd0, mem_rf_zip[38:37]}, 32'd0);
      step();
      data_sram_data_ok = 1'b0;
      settle();
      chk("rw_after_valid", {31'd0, mem_to_wb_valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/memu_resp.md
Name: memu_resp

Overview:
- Memory-access stage between EXE and WB of the 5-stage pipeline.
- Accepts the EXE bundle, waits for the data-SRAM response of the access EXE issued, and aligns and sign/zero-extends load data.
- Forwards the final write-back value to WB and forwards hazard/bypass info to ID.
- Uses a valid/allowin handshake on both sides and tolerates a variable-latency data_ok response.

Parameters:
- IN_LEN, 75, width of exe_to_mem_zip.
- OUT_LEN, 70, width of mem_to_wb_zip.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- exe_to_mem_valid  in  1  EXE holds a valid bundle
- mem_allowin  out  1  MEM can accept a bundle this cycle
- exe_to_mem_zip  in  IN_LEN  {ld_op[2:0], mem_we, res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}, MSB first
- wb_allowin  in  1  WB can accept a bundle
- mem_to_wb_valid  out  1  MEM bundle valid and ready to leave
- mem_to_wb_zip  out  OUT_LEN  {rf_we, rf_waddr[4:0], final_result[31:0], pc[31:0]}
- data_sram_data_ok  in  1  one-cycle pulse: response for the oldest outstanding access
- data_sram_rdata  in  32  read data, valid only when data_ok=1
- mem_rf_zip  out  39  {mem_busy, rf_we&valid, rf_waddr, final_result}, to ID bypass

Behaviour:
- Reset (resetn=0 at posedge):
  - mem_valid=0, state=IDLE, rdata buffer=0.
  - Outputs then: mem_allowin=1, mem_to_wb_valid=0, mem_rf_zip[37]=0, mem_rf_zip[38]=0.
- Accept rule:
  - When exe_to_mem_valid & mem_allowin at posedge, latch the zip and set mem_valid=1.
  - Otherwise mem_valid <= mem_valid & ~(ready_go & wb_allowin).
- need_resp = res_from_mem | mem_we. Stores also wait for their data_ok.
- State machine, tracking the current valid entry:
  - IDLE: no valid entry, or entry needs no response.
  - WAIT: need_resp entry, no data_ok yet.
  - HELD: data_ok received and rdata buffered, but WB stalled.
- Entering a latched entry:
  - need_resp=1 -> WAIT.
  - need_resp=0 -> IDLE.
- In WAIT:
  - data_ok=1 with wb_allowin=1 -> entry leaves this cycle. Next state is WAIT/IDLE for the incoming entry, or IDLE if none.
  - data_ok=1 with wb_allowin=0 -> capture rdata, go to HELD.
  - No data_ok -> stay in WAIT.
- In HELD: leave when wb_allowin=1. Next state is chosen as for a new entry.
- ready_go:
  - Entry not needing a response: 1.
  - WAIT: data_ok.
  - HELD: 1.
- mem_allowin = ~mem_valid | (ready_go & wb_allowin).
- mem_to_wb_valid = mem_valid & ready_go. It is combinational, so data_ok-to-WB latency is 0 cycles.
- data_ok arriving in IDLE or HELD is stale: ignore it, no state change.
- Load data: raw = HELD ? buffer : data_sram_rdata; a = alu_result[1:0].
  - ld_op 000 (W): raw.
  - ld_op 001 (B): sign-extend raw byte a.
  - ld_op 011 (BU): zero-extend raw byte a.
  - ld_op 010 (H): sign-extend raw half a[1].
  - ld_op 100 (HU): zero-extend raw half a[1].
  - Other ld_op values: treat as W.
  - Byte a = raw[8a+7:8a]. Half 0 = [15:0], half 1 = [31:16].
  - a[0] is ignored for halfword loads; the alignment exception is raised upstream.
- final_result = res_from_mem ? extended load : alu_result.
- mem_busy = mem_valid & res_from_mem & ~ready_go. ID must stall on a RAW hazard with this entry rather than bypass.
- Output gating:
  - mem_to_wb_zip.rf_we = rf_we & mem_valid.
  - mem_rf_zip fields are gated with mem_valid except rf_waddr and final_result.
- Simultaneous events: the leaving entry and the accepted next entry in the same cycle are legal. The new entry's state is set from its own need_resp; the old buffer is not reused.
- Reset mid-WAIT drops the entry. A later data_ok is stale and ignored (the SRAM side is reset together).

Test Plan:
- Non-memory op (alu_result=0x1234, rf_we=1, waddr=5), wb_allowin=1:
  - mem_to_wb_valid is high the cycle after accept.
  - final_result=0x1234; mem_allowin stays 1.
- ld.w at 0x100, data_ok 3 cycles after accept with rdata=0xDEADBEEF:
  - mem_busy=1 for 3 cycles, mem_allowin=0.
  - mem_to_wb_valid=1 in the data_ok cycle with final=0xDEADBEEF.
- ld.b at addr 0x103 with rdata=0x80FF0011 -> final=0xFFFFFF80.
- ld.bu at the same address -> final=0x00000080.
- ld.h at 0x102 -> final=0xFFFF80FF.
- ld.hu at 0x100 -> final=0x00000011.
- ld.w, data_ok with wb_allowin=0 for 2 cycles:
  - HELD holds 0xCAFEF00D while the bus rdata changes.
  - The entry leaves when wb_allowin rises, with final=0xCAFEF00D.
- Store (mem_we=1, rf_we=0) followed back-to-back by an ALU op:
  - The store waits for data_ok and the ALU op is accepted in the same cycle.
  - A stale data_ok pulse injected while IDLE causes no state change.
- Reset asserted during WAIT, then data_ok:
  - mem_valid=0, mem_allowin=1, mem_to_wb_valid stays 0.
